// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and emits it one bit per clock with frame/done strobes.
module piso_shift_tx #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             data_out,
  output logic             frame,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg, sreg_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             last_bit;
  logic             accept;

  // The last bit cycle also opens the load window so words can stream gap-free.
  assign last_bit   = (state == SHIFT) && (cnt == '0);
  assign load_ready = (state == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      sreg  <= sreg_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sreg_nx  = sreg;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = SHIFT;
          sreg_nx  = data_in;
          cnt_nx   = CW'(WIDTH - 1);
        end
      end
      SHIFT: begin
        if (accept) begin
          sreg_nx = data_in;
          cnt_nx  = CW'(WIDTH - 1);
        end else if (last_bit) begin
          state_nx = IDLE;
          sreg_nx  = '0;
        end else begin
          sreg_nx = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
          cnt_nx  = cnt - CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decode registered state only; no input reaches them combinationally.
  assign frame    = (state == SHIFT);
  assign done     = last_bit;
  assign data_out = frame ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : IDLE_LEVEL;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Scoreboard bench for piso_shift_tx: three instances cover MSB-first,
// LSB-first and IDLE_LEVEL=1 configurations.
module tb_piso_shift_tx;

  typedef struct {
    logic b;
    logic last;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din [3];
  logic       lv  [3];
  logic       rdy [3];
  logic       dout[3];
  logic       frm [3];
  logic       dn  [3];

  const logic idle_lvl [3] = '{1'b0, 1'b0, 1'b1};
  const logic msb      [3] = '{1'b1, 1'b0, 1'b1};

  exp_t       q [3][$];
  exp_t       e_m;
  int         run [3] = '{0, 0, 0};
  int         last_run [3] = '{0, 0, 0};
  int         done_cnt [3] = '{0, 0, 0};
  logic [7:0] rx1 = 8'h00;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .data_in(din[0]), .load_valid(lv[0]),
    .load_ready(rdy[0]), .data_out(dout[0]), .frame(frm[0]), .done(dn[0]));

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .data_in(din[1]), .load_valid(lv[1]),
    .load_ready(rdy[1]), .data_out(dout[1]), .frame(frm[1]), .done(dn[1]));

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_dut2 (
    .clk(clk), .reset(reset), .data_in(din[2]), .load_valid(lv[2]),
    .load_ready(rdy[2]), .data_out(dout[2]), .frame(frm[2]), .done(dn[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected bit per frame cycle; idle cycles must show idle level.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        if (frm[i]) begin
          run[i]++;
          if (q[i].size() == 0) begin
            chk($sformatf("dut%0d_unexpected_frame", i), 32'd1, 32'd0);
          end else begin
            e_m = q[i].pop_front();
            chk($sformatf("dut%0d_bit_done", i), {30'd0, dn[i], dout[i]}, {30'd0, e_m.last, e_m.b});
          end
          if (i == 1) rx1 = {dout[1], rx1[7:1]};
        end else begin
          if (run[i] > 0) begin
            last_run[i] = run[i];
            run[i] = 0;
          end
          if (q[i].size() != 0)
            chk($sformatf("dut%0d_frame_gap", i), 32'd0, 32'd1);
          chk($sformatf("dut%0d_idle_out", i), {30'd0, dn[i], dout[i]}, {30'd0, 1'b0, idle_lvl[i]});
        end
        if (dn[i]) done_cnt[i]++;
      end
    end
  end

  task automatic send(input int i, input logic [7:0] w);
    bit acc;
    acc = 1'b0;
    @(negedge clk);
    lv[i] = 1'b1;
    din[i] = w;
    for (int c = 0; c < 50; c++) begin
      if (rdy[i]) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!acc) begin
      chk($sformatf("dut%0d_load_timeout", i), 32'd0, 32'd1);
      lv[i] = 1'b0;
      return;
    end
    @(posedge clk);
    for (int j = 0; j < 8; j++)
      q[i].push_back('{b: w[msb[i] ? 7 - j : j], last: (j == 7)});
    #1 lv[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #1;
      if (q[i].size() == 0 && !frm[i]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk($sformatf("dut%0d_drain_timeout", i), 32'd0, 32'd1);
  endtask

  initial begin
    int d0;
    for (int i = 0; i < 3; i++) begin
      lv[i] = 1'b0;
      din[i] = 8'h00;
    end
    #12;
    // Reset state
    for (int i = 0; i < 3; i++)
      chk($sformatf("dut%0d_reset_outs", i), {28'd0, dout[i], frm[i], dn[i], rdy[i]},
          {28'd0, idle_lvl[i], 1'b0, 1'b0, 1'b1});
    @(posedge clk); #2 reset = 1'b0;

    // 1: A5 MSB first
    d0 = done_cnt[0];
    send(0, 8'hA5);
    drain(0);
    chk("t1_frame_len", last_run[0], 8);
    chk("t1_done_count", done_cnt[0] - d0, 1);
    chk("t1_ready_after", {31'd0, rdy[0]}, 1);

    // 2: 01 LSB first, downstream reassembly
    rx1 = 8'h00;
    send(1, 8'h01);
    drain(1);
    chk("t2_frame_len", last_run[1], 8);
    chk("t2_rx_word", {24'd0, rx1}, 32'h01);

    // 3: back-to-back F0 then 0F
    d0 = done_cnt[0];
    send(0, 8'hF0);
    send(0, 8'h0F);
    drain(0);
    chk("t3_frame_len", last_run[0], 16);
    chk("t3_done_count", done_cnt[0] - d0, 2);

    // 4: busy rejection
    send(0, 8'hC3);
    @(negedge clk);
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      lv[0] = 1'b1;
      din[0] = 8'hFF;
      chk($sformatf("t4_busy_ready_c%0d", c), {31'd0, rdy[0]}, 0);
    end
    @(negedge clk);
    lv[0] = 1'b0;
    drain(0);
    chk("t4_frame_len", last_run[0], 8);

    // 5: asynchronous reset mid-word
    d0 = done_cnt[0];
    send(0, 8'hFF);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t5_reset_outs", {28'd0, dout[0], frm[0], dn[0], rdy[0]}, {28'd0, 4'b0001});
    q[0].delete();
    run[0] = 0;
    @(posedge clk); #2 reset = 1'b0;
    chk("t5_no_done_aborted", done_cnt[0] - d0, 0);
    send(0, 8'h81);
    drain(0);
    chk("t5_frame_len", last_run[0], 8);
    chk("t5_done_count", done_cnt[0] - d0, 1);

    // 6: IDLE_LEVEL=1, no load for 20 cycles
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("t6_idle_outs", {28'd0, dout[2], frm[2], dn[2], rdy[2]}, {28'd0, 4'b1001});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
